adc_scan_controller: RTL and testbench

- Sequences the two-channel 10-bit SAR ADC.
- Selects the channel, pulses the ADC restart and times the 10-bit conversion.
- Captures the result and delivers it downstream over a valid/ready handshake.
- Supports single-scan and continuous round-robin modes across the enabled channels.

---
 rtl/adc_pkg.sv | 25 ++
 rtl/adc_next_ch.sv | 23 ++
 rtl/adc_scan_controller.sv | 123 ++++++++++++
 tb/tb_adc_scan_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the two-channel SAR ADC scan controller.
package adc_pkg;

  localparam int ADC_DATA_W      = 10;
  localparam int ADC_CONV_CYCLES = 10;
  localparam int ADC_NUM_CH      = 2;
  localparam int ADC_CH_W        = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CONV,
    CAPTURE,
    OUT
  } adc_state_t;

  // Lowest-numbered enabled channel; 0 when nothing is enabled.
  function automatic logic [ADC_CH_W-1:0] lowest_ch(input logic [ADC_NUM_CH-1:0] en);
    lowest_ch = '0;
    for (int i = ADC_NUM_CH - 1; i >= 0; i--) begin
      if (en[i]) lowest_ch = ADC_CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/adc_next_ch.sv
// Picks the next enabled channel above the current one (ascending, wrapping)
// and flags when the current channel is the last of the pass.
module adc_next_ch
  import adc_pkg::*;
(
  input  logic [ADC_NUM_CH-1:0] snapshot,
  input  logic [ADC_CH_W-1:0]   ch,
  output logic [ADC_CH_W-1:0]   next_ch,
  output logic                  last_in_pass
);

  always_comb begin
    next_ch      = lowest_ch(snapshot);
    last_in_pass = 1'b1;
    for (int i = ADC_NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(ch) && snapshot[i]) begin
        next_ch      = ADC_CH_W'(i);
        last_in_pass = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_scan_controller.sv
// Scan sequencer for the two-channel 10-bit SAR ADC with valid/ready output.
// Optional threshold alarm is built when ADC_THRESH_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start with a nonzero channel enable
// START   | adc_restart pulse; ADC loads its midscale code
// CONV    | counting CONV_CYCLES while the SAR resolves bits
// CAPTURE | result is final; latch it into the output register
// OUT     | sample_valid held until sample_ready, then next channel
module adc_scan_controller
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int CONV_CYCLES = ADC_CONV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [ADC_NUM_CH-1:0] ch_enable,
  output logic                  adc_restart,
  output logic [ADC_CH_W-1:0]   adc_channel,
  input  logic [DATA_W-1:0]     adc_result,
  output logic [DATA_W-1:0]     sample_data,
  output logic [ADC_CH_W-1:0]   sample_ch,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy
`ifdef ADC_THRESH_EN
  ,
  input  logic [DATA_W-1:0]     thresh,
  output logic                  alarm
`endif
);

  adc_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [ADC_NUM_CH-1:0] snap;
  logic [ADC_CH_W-1:0]   next_ch;
  logic                  last_in_pass;

  adc_next_ch u_next_ch (
    .snapshot    (snap),
    .ch          (adc_channel),
    .next_ch     (next_ch),
    .last_in_pass(last_in_pass)
  );

  always_comb begin
    state_nxt   = state;
    adc_restart = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (start && ch_enable != '0) state_nxt = START;
      START: begin
        adc_restart = 1'b1;
        state_nxt   = CONV;
      end
      CONV:    if (cnt == CNT_W'(CONV_CYCLES - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUT;
      OUT: begin
        if (sample_ready) begin
          if (!last_in_pass)                      state_nxt = START;
          else if (continuous && ch_enable != '0) state_nxt = START;
          else                                    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ADC keeps re-comparing after the last bit, so the result is only
  // trustworthy at the fixed CAPTURE count; adc_channel only moves at
  // scan start or on a transfer so the input mux never switches mid-conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      snap         <= '0;
      adc_channel  <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
`ifdef ADC_THRESH_EN
      alarm        <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && ch_enable != '0) begin
            snap        <= ch_enable;
            adc_channel <= lowest_ch(ch_enable);
          end
        end
        START: cnt <= '0;
        CONV:  cnt <= cnt + CNT_W'(1);
        CAPTURE: begin
          sample_data  <= adc_result;
          sample_ch    <= adc_channel;
          sample_valid <= 1'b1;
`ifdef ADC_THRESH_EN
          alarm        <= (adc_result > thresh);
`endif
        end
        OUT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            if (!last_in_pass) begin
              adc_channel <= next_ch;
            end else if (continuous) begin
              snap <= ch_enable;
              if (ch_enable != '0) adc_channel <= lowest_ch(ch_enable);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Directed plus randomized bench for adc_scan_controller with a bit-serial
// SAR ADC model; threshold checks are built when ADC_THRESH_EN is defined.
module tb_adc_scan_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] ch_enable = 2'b00;
  logic       adc_restart;
  logic [0:0] adc_channel;
  logic [9:0] adc_res = 10'h000;
  logic [9:0] sample_data;
  logic [0:0] sample_ch;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic       busy;
`ifdef ADC_THRESH_EN
  logic [9:0] thresh = 10'h200;
  logic       alarm;
`endif

  int checks = 0;
  int errors = 0;

  logic [9:0] target [2];
  int         bp = -2;
  logic [9:0] tmp;

  adc_scan_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .ch_enable   (ch_enable),
    .adc_restart (adc_restart),
    .adc_channel (adc_channel),
    .adc_result  (adc_res),
    .sample_data (sample_data),
    .sample_ch   (sample_ch),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy)
`ifdef ADC_THRESH_EN
    ,
    .thresh      (thresh),
    .alarm       (alarm)
`endif
  );

  always #5 clk = ~clk;

  // SAR model: restart loads midscale, one bit resolves per clock using the
  // currently selected channel, then the sequence wraps and starts over.
  always @(posedge clk) begin
    if (adc_restart) begin
      adc_res <= 10'h200;
      bp      <= 9;
    end else if (bp >= 0) begin
      tmp     = adc_res;
      tmp[bp] = target[adc_channel][bp];
      if (bp > 0) tmp[bp-1] = 1'b1;
      adc_res <= tmp;
      bp      <= bp - 1;
    end else if (bp == -1) begin
      adc_res <= 10'h200;
      bp      <= 9;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles until sample_valid, restart pulses seen and channel moves.
  task automatic wait_valid(input int n0, output int n, output int nrst, output int glitch);
    logic [0:0] ch0;
    n      = n0;
    nrst   = int'(adc_restart);
    glitch = 0;
    ch0    = adc_channel;
    while (!sample_valid && n < 60) begin
      tick();
      n++;
      nrst += int'(adc_restart);
      if (adc_channel !== ch0) glitch++;
    end
  endtask

  int n, nr, gl, bad, d;
  int exp_q[$];
  logic [9:0] hold_data;
  logic [0:0] hold_ch;
  logic [1:0] en;

  initial begin
    target[0] = 10'h000;
    target[1] = 10'h000;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_restart", adc_restart, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_channel", adc_channel, 0);
    check("rst_data", sample_data, 0);
    check("rst_ch", sample_ch, 0);
    reset = 1'b0;
    tick();

    // Single scan, channel 0 only
    target[0] = 10'h155;
    ch_enable = 2'b01;
    sample_ready = 1'b1;
    pulse_start();
    check("t1_busy", busy, 1);
    wait_valid(0, n, nr, gl);
    check("t1_latency", n, 12);
    check("t1_restart_cnt", nr, 1);
    check("t1_data", sample_data, 10'h155);
    check("t1_ch", sample_ch, 0);
    tick();
    check("t1_valid_drop", sample_valid, 0);
    check("t1_idle", busy, 0);

    // Continuous round-robin, dropping continuous mid pass
    target[0] = 10'h3FF;
    target[1] = 10'h001;
    ch_enable = 2'b11;
    continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) continuous = 1'b0;
      wait_valid(0, n, nr, gl);
      check("t2_period", n, 12);
      check("t2_restart_cnt", nr, 1);
      check("t2_ch_stable", gl, 0);
      check("t2_ch", sample_ch, i % 2);
      check("t2_data", sample_data, target[i%2]);
      tick();
    end
    check("t2_idle", busy, 0);

    // Backpressure
    sample_ready = 1'b0;
    target[0] = 10'h0A5;
    target[1] = 10'h35A;
    pulse_start();
    wait_valid(0, n, nr, gl);
    check("t3_latency", n, 12);
    hold_data = sample_data;
    hold_ch   = sample_ch;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_data !== hold_data || sample_ch !== hold_ch || !sample_valid || adc_restart) bad++;
    end
    check("t3_stall_stable", bad, 0);
    check("t3_held_data", hold_data, 10'h0A5);
    sample_ready = 1'b1;
    tick();
    check("t3_next_restart", adc_restart, 1);
    check("t3_next_channel", adc_channel, 1);
    check("t3_valid_drop", sample_valid, 0);
    wait_valid(0, n, nr, gl);
    check("t3_ch1_data", sample_data, 10'h35A);
    check("t3_ch1_ch", sample_ch, 1);
    tick();
    check("t3_idle", busy, 0);

    // start with no channels enabled, then start while busy
    ch_enable = 2'b00;
    pulse_start();
    check("t4_zero_en_busy", busy, 0);
    check("t4_zero_en_restart", adc_restart, 0);
    ch_enable = 2'b01;
    target[0] = 10'h2C3;
    pulse_start();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy_start_restart", adc_restart, 0);
    wait_valid(4, n, nr, gl);
    check("t4_latency", n, 12);
    check("t4_extra_restart", nr, 0);
    check("t4_data", sample_data, 10'h2C3);
    tick();
    check("t4_idle", busy, 0);

    // Reset at conversion count 5, and reset with a pending sample
    target[0] = 10'($urandom);
    pulse_start();
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_restart", adc_restart, 0);
    check("t5_rst_valid", sample_valid, 0);
    sample_ready = 1'b0;
    pulse_start();
    wait_valid(0, n, nr, gl);
    check("t5_after_latency", n, 12);
    check("t5_after_data", sample_data, target[0]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_pending_dropped", sample_valid, 0);
    check("t5_pending_busy", busy, 0);

    // Randomized single scans; ch_enable scrambled after the snapshot
    for (int r = 0; r < 6; r++) begin
      en = 2'($urandom_range(1, 3));
      target[0] = 10'($urandom);
      target[1] = 10'($urandom);
      ch_enable = en;
      continuous = 1'b0;
      sample_ready = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 2; c++) if (en[c]) exp_q.push_back(c);
      pulse_start();
      ch_enable = 2'($urandom);
      for (int k = 0; k < exp_q.size(); k++) begin
        wait_valid(0, n, nr, gl);
        check("rnd_latency", n, 12);
        check("rnd_ch", sample_ch, exp_q[k]);
        check("rnd_data", sample_data, target[exp_q[k]]);
        d = $urandom_range(0, 4);
        repeat (d) tick();
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
      end
      check("rnd_idle", busy, 0);
    end

`ifdef ADC_THRESH_EN
    // Threshold alarm, strict greater-than
    thresh = 10'h200;
    ch_enable = 2'b01;
    sample_ready = 1'b0;
    target[0] = 10'h201;
    pulse_start();
    wait_valid(0, n, nr, gl);
    check("th_valid_a", sample_valid, 1);
    check("th_alarm_above", alarm, 1);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    target[0] = 10'h200;
    pulse_start();
    wait_valid(0, n, nr, gl);
    check("th_valid_b", sample_valid, 1);
    check("th_alarm_equal", alarm, 0);
    sample_ready = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
